axi_wstrb_write_slave: RTL and testbench

// - AXI4 write-channel responder for a 4 KB local buffer of DATA_W-bit words.
// - Consumes AW/W/B and merges each beat into RAM under WSTRB, one byte lane at a time.
// - Receiving end of the byte-enable scheme the accelerator uses on its initiator side.
// - Side read port (RD_*) gives the accelerator datapath and the bench access to buffer contents.

---
 rtl/axi_wstrb_write_slave.sv | 170 +++++++++++++++++
 tb/tb_axi_wstrb_write_slave.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wstrb_write_slave.sv
// AXI4 write-only responder: merges WSTRB-masked beats into a 4 KB word buffer and exposes a side read port.
// Define AXI_WSTRB_CHECK_EN to drop strobes outside the legal lane window and flag SLVERR.
module axi_wstrb_write_slave #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 512,
    parameter int ID_W   = 6
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic [ID_W-1:0]                       AWID,
    input  logic [ADDR_W-1:0]                     AWADDR,
    input  logic [7:0]                            AWLEN,
    input  logic [2:0]                            AWSIZE,
    input  logic [1:0]                            AWBURST,
    input  logic                                  AWVALID,
    output logic                                  AWREADY,
    input  logic [DATA_W-1:0]                     WDATA,
    input  logic [DATA_W/8-1:0]                   WSTRB,
    input  logic                                  WLAST,
    input  logic                                  WVALID,
    output logic                                  WREADY,
    output logic [ID_W-1:0]                       BID,
    output logic [1:0]                            BRESP,
    output logic                                  BVALID,
    input  logic                                  BREADY,
    input  logic [ADDR_W-$clog2(DATA_W/8)-1:0]    RD_ADDR,
    output logic [DATA_W-1:0]                     RD_DATA
);

    localparam int NBYTES = DATA_W / 8;
    localparam int LG     = $clog2(NBYTES);
    localparam int WORDS  = 1 << (ADDR_W - LG);
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t            state;
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [7:0]        beat;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              err;

    logic [DATA_W-1:0] mem [WORDS];

    logic              aw_hs;
    logic              w_hs;
    logic              we;
    logic              strb_bad;
    logic [NBYTES-1:0] strb_eff;
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] addr_next;

`ifdef AXI_WSTRB_CHECK_EN
    localparam logic [LG:0] LANE_ONE = 1;
    logic [LG:0]       lane_lo;
    logic [LG:0]       lane_hi;
    logic [LG:0]       lane_n;
    logic [NBYTES-1:0] lane_ok;
`endif

    always_comb begin
        aw_hs     = AWVALID && AWREADY;
        w_hs      = WVALID && WREADY;
        we        = w_hs && !err && !RST;
        step      = ADDR_ONE << size;
        addr_next = (addr & ~(step - ADDR_ONE)) + step;
`ifdef AXI_WSTRB_CHECK_EN
        // Legal lanes run from the byte offset up to the end of the size-aligned transfer.
        lane_n  = LANE_ONE << size;
        lane_lo = {1'b0, addr[LG-1:0]};
        lane_hi = (lane_lo & ~(lane_n - LANE_ONE)) + lane_n;
        lane_ok = '0;
        for (int i = 0; i < NBYTES; i++) begin
            lane_ok[i] = (i >= int'(lane_lo)) && (i < int'(lane_hi));
        end
        strb_eff = WSTRB & lane_ok;
        strb_bad = |(WSTRB & ~lane_ok);
`else
        strb_eff = WSTRB;
        strb_bad = 1'b0;
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            AWREADY <= 1'b1;
            WREADY  <= 1'b0;
            BVALID  <= 1'b0;
            BID     <= '0;
            BRESP   <= RESP_OKAY;
            id      <= '0;
            addr    <= '0;
            len     <= '0;
            beat    <= '0;
            size    <= '0;
            burst   <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (aw_hs) begin
                        id      <= AWID;
                        addr    <= AWADDR;
                        len     <= AWLEN;
                        size    <= AWSIZE;
                        burst   <= AWBURST;
                        beat    <= '0;
                        // WRAP and the reserved encoding share burst[1]; oversize beats are unsupported.
                        err     <= AWBURST[1] || (int'(AWSIZE) > LG);
                        AWREADY <= 1'b0;
                        WREADY  <= 1'b1;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (w_hs) begin
                        beat <= beat + 8'd1;
                        if (burst == 2'b01) begin
                            addr <= addr_next;
                        end
                        if (WLAST) begin
                            WREADY <= 1'b0;
                            BVALID <= 1'b1;
                            BID    <= id;
                            BRESP  <= (err || strb_bad || (beat != len)) ? RESP_SLVERR : RESP_OKAY;
                            state  <= RESP;
                        end else if (strb_bad || (beat == len)) begin
                            err <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (BVALID && BREADY) begin
                        BVALID  <= 1'b0;
                        AWREADY <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the buffer has no reset; clearing a RAM every reset costs a full write pass and blocks RAM mapping.
    always_ff @(posedge CLK) begin
        if (we) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (strb_eff[i]) begin
                    mem[addr[ADDR_W-1:LG]][i*8 +: 8] <= WDATA[i*8 +: 8];
                end
            end
        end
    end

    // NOTE: non-blocking read and write in the same edge give read-before-write on a shared word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            RD_DATA <= '0;
        end else begin
            RD_DATA <= mem[RD_ADDR];
        end
    end

endmodule

// File: tb/tb_axi_wstrb_write_slave.sv
// Randomised scoreboard bench for axi_wstrb_write_slave: byte-array reference model, B and read-port monitors.
// Honours AXI_WSTRB_CHECK_EN the same way as the design build.
module tb_axi_wstrb_write_slave;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 512;
    localparam int ID_W   = 6;
    localparam int NB     = DATA_W / 8;

    logic              CLK = 1'b0;
    logic              RST;
    logic [ID_W-1:0]   AWID;
    logic [ADDR_W-1:0] AWADDR;
    logic [7:0]        AWLEN;
    logic [2:0]        AWSIZE;
    logic [1:0]        AWBURST;
    logic              AWVALID;
    logic              AWREADY;
    logic [DATA_W-1:0] WDATA;
    logic [NB-1:0]     WSTRB;
    logic              WLAST;
    logic              WVALID;
    logic              WREADY;
    logic [ID_W-1:0]   BID;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;
    logic [5:0]        RD_ADDR;
    logic [DATA_W-1:0] RD_DATA;

    axi_wstrb_write_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .CLK(CLK), .RST(RST),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } b_exp_t;

    b_exp_t            b_q[$];
    logic [DATA_W-1:0] rd_q[$];
    int                n_checks = 0;
    int                n_fails  = 0;
    logic              rd_req   = 1'b0;
    logic              rd_fire  = 1'b0;

    // Reference model: a flat byte array plus the state of the burst in flight.
    logic [7:0] mmem [4096];
    int         m_addr, m_len, m_size, m_burst, m_beat, m_id;
    bit         m_err;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fails++;
        $display("FAIL %s: DUT handshake did not arrive within the cycle bound", name);
    endtask

    function automatic logic [DATA_W-1:0] model_word(input int w);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < NB; i++) r[i*8 +: 8] = mmem[w*NB + i];
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic void model_aw(input int id, input int addr, input int len, input int size, input int bt);
        m_id    = id;
        m_addr  = addr;
        m_len   = len;
        m_size  = size;
        m_burst = bt;
        m_beat  = 0;
        m_err   = (bt >= 2) || (size > 6);
    endfunction

    function automatic void model_beat(input logic [DATA_W-1:0] data, input logic [NB-1:0] strb, input bit last);
        int nb, lo, hi, base;
        bit bad, legal;
        b_exp_t e;
        nb   = 1 << m_size;
        lo   = m_addr % NB;
        hi   = (lo / nb) * nb + nb;
        base = (m_addr / NB) * NB;
        bad  = 0;
        for (int i = 0; i < NB; i++) begin
            if (strb[i]) begin
                legal = (i >= lo) && (i < hi);
`ifdef AXI_WSTRB_CHECK_EN
                if (!legal) bad = 1;
                if (!m_err && legal) mmem[base + i] = data[i*8 +: 8];
`else
                if (!m_err) mmem[base + i] = data[i*8 +: 8];
`endif
            end
        end
        if (last && (m_beat != m_len)) m_err = 1;
        if (!last && (m_beat == m_len)) m_err = 1;
        if (bad) m_err = 1;
        if (m_burst == 1) m_addr = ((m_addr / nb) * nb + nb) % 4096;
        m_beat++;
        if (last) begin
            e.id   = ID_W'(m_id);
            e.resp = m_err ? 2'b10 : 2'b00;
            b_q.push_back(e);
        end
    endfunction

    // Read-port monitor: a request issued before an edge is compared on the following falling edge.
    always @(posedge CLK) rd_fire <= rd_req;

    initial begin : rd_monitor
        logic [DATA_W-1:0] exp;
        forever begin
            @(negedge CLK);
            if (rd_fire) begin
                if (rd_q.size() == 0) begin
                    timeout_fail("rd_unexpected");
                end else begin
                    exp = rd_q.pop_front();
                    check("rd_data", RD_DATA, exp);
                end
            end
        end
    end

    // B monitor: every cycle BVALID is up, BID/BRESP must equal the head of the expected queue.
    initial begin : b_monitor
        forever begin
            @(negedge CLK);
            if (!RST && BVALID) begin
                if (b_q.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL b_unexpected: got BID=%0h BRESP=%0b, required no response", BID, BRESP);
                end else begin
                    check("bid", BID, b_q[0].id);
                    check("bresp", BRESP, b_q[0].resp);
                    if (BREADY) void'(b_q.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic aw_send(input logic [ID_W-1:0] id, input logic [11:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] bt);
        int n = 0;
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = bt; AWVALID = 1'b1;
        while (!AWREADY && n < 50) begin @(posedge CLK); #1; n++; end
        if (n == 50) timeout_fail("aw_ready");
        @(posedge CLK); #1;
        AWVALID = 1'b0;
        model_aw(int'(id), int'(addr), int'(len), int'(size), int'(bt));
    endtask

    task automatic w_beat(input logic [DATA_W-1:0] data, input logic [NB-1:0] strb, input bit last);
        int n = 0;
        WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1;
        while (!WREADY && n < 50) begin @(posedge CLK); #1; n++; end
        if (n == 50) timeout_fail("w_ready");
        @(posedge CLK); #1;
        WVALID = 1'b0; WLAST = 1'b0;
        model_beat(data, strb, last);
    endtask

    task automatic b_take(input int hold);
        int n = 0;
        while (!BVALID && n < 50) begin @(posedge CLK); #1; n++; end
        if (n == 50) timeout_fail("b_valid");
        repeat (hold) begin @(posedge CLK); #1; end
        BREADY = 1'b1;
        @(posedge CLK); #1;
        BREADY = 1'b0;
    endtask

    task automatic burst(input logic [ID_W-1:0] id, input logic [11:0] addr, input int len, input int size,
                         input int bt, input int wlast_at, input logic [NB-1:0] strb, input bit rand_strb,
                         input int hold);
        aw_send(id, addr, 8'(len), 3'(size), 2'(bt));
        for (int k = 0; k <= wlast_at; k++) begin
            logic [NB-1:0] s;
            s = rand_strb ? {$urandom, $urandom} : strb;
            if ($urandom_range(0, 3) == 0) begin @(posedge CLK); #1; end
            w_beat(rand_data(), s, k == wlast_at);
        end
        b_take(hold);
    endtask

    task automatic rd_word(input int idx);
        RD_ADDR = 6'(idx);
        rd_q.push_back(model_word(idx));
        rd_req = 1'b1;
        @(posedge CLK); #1;
        rd_req = 1'b0;
    endtask

    task automatic read_all();
        for (int w = 0; w < 64; w++) rd_word(w);
    endtask

    initial begin
        logic [DATA_W-1:0] d;
        int len, wl, r;

        RST = 1'b1;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0; RD_ADDR = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_awready", AWREADY, 1);
        check("rst_wready", WREADY, 0);
        check("rst_bvalid", BVALID, 0);
        check("rst_bid", BID, 0);
        check("rst_bresp", BRESP, 0);
        check("rst_rd_data", RD_DATA, 0);
        RST = 1'b0;

        // Fill the whole buffer so every later read has a known reference.
        burst(6'd1, 12'h000, 63, 6, 1, 63, '1, 0, 0);
        read_all();

        burst(6'h2A, 12'h040, 0, 6, 1, 0, '1, 0, 1);
        rd_word(1);

        burst(6'd3, 12'h003, 3, 0, 1, 3, 64'h78, 0, 0);
        rd_word(0);

        burst(6'd4, 12'hFC0, 1, 6, 1, 1, '1, 0, 0);
        rd_word(63);
        rd_word(0);

        burst(6'd5, 12'h100, 3, 6, 1, 1, '1, 0, 0);
        check("idle_after_early_wlast", AWREADY, 1);
        rd_word(4); rd_word(5); rd_word(6);

        burst(6'd6, 12'h200, 1, 6, 2, 1, '1, 0, 5);
        rd_word(8); rd_word(9);

        burst(6'd7, 12'h000, 0, 2, 1, 0, 64'hFF, 0, 0);
        rd_word(0);

        burst(6'd8, 12'h300, 1, 6, 1, 3, '1, 1, 2);
        rd_word(12); rd_word(13); rd_word(14);

        // Same-cycle read of the word being written returns old data; the next cycle sees the new data.
        aw_send(6'd9, 12'h140, 8'd0, 3'd6, 2'b01);
        d = rand_data();
        WDATA = d; WSTRB = '1; WLAST = 1'b1; WVALID = 1'b1;
        r = 0;
        while (!WREADY && r < 50) begin @(posedge CLK); #1; r++; end
        if (r == 50) timeout_fail("w_ready_rbw");
        RD_ADDR = 6'd5;
        rd_q.push_back(model_word(5));
        rd_req = 1'b1;
        @(posedge CLK); #1;
        WVALID = 1'b0; WLAST = 1'b0;
        model_beat(d, '1, 1);
        rd_q.push_back(model_word(5));
        @(posedge CLK); #1;
        rd_req = 1'b0;
        b_take(0);

        // Reset in the middle of a burst: written bytes stay, no response appears.
        aw_send(6'd10, 12'h400, 8'd3, 3'd6, 2'b01);
        w_beat(rand_data(), '1, 0);
        w_beat(rand_data(), '1, 0);
        RST = 1'b1;
        @(posedge CLK); #1;
        check("midrst_awready", AWREADY, 1);
        check("midrst_wready", WREADY, 0);
        check("midrst_bvalid", BVALID, 0);
        RST = 1'b0;
        @(posedge CLK); #1;
        rd_word(16); rd_word(17); rd_word(18);

        for (int t = 0; t < 40; t++) begin
            r   = $urandom_range(0, 7);
            len = $urandom_range(0, 7);
            case ($urandom_range(0, 7))
                0:       wl = len + 2;
                1:       wl = (len > 0) ? $urandom_range(0, len - 1) : len;
                default: wl = len;
            endcase
            burst(6'($urandom), 12'($urandom), len, $urandom_range(0, 7),
                  (r < 4) ? 1 : (r < 6) ? 0 : (r == 6) ? 2 : 3,
                  wl, '0, 1, $urandom_range(0, 2));
            for (int k = 0; k < 4; k++) rd_word($urandom_range(0, 63));
            if (t % 10 == 9) read_all();
        end

        read_all();
        repeat (3) @(posedge CLK);
        check("b_queue_drained", 32'(b_q.size()), 0);
        check("rd_queue_drained", 32'(rd_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
